seg_scan_ctrl: RTL and testbench

Parametrised, single-clock multiplexed seven-segment display controller: the next generation of the lab display driver. It holds one 4-bit hex value per digit, plus per-digit decimal-point, blank and blink attributes. It scans NUM_DIGITS common-anode digits from a clock-enable tick rather than a derived clock, and adds leading-zero suppression and a synchronous clear. It sits between the board-level register/switch logic and the anode/segment pins.

---
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner. It holds per-digit hex values and
// their attributes, and drives one digit per REFRESH_DIV-cycle slot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 32,
    parameter int SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [SEL_W-1:0]      sel,
    input  logic [3:0]            num,
    input  logic                  dp_in,
    input  logic                  blank_in,
    input  logic                  blink_in,
    input  logic                  clear,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] anode
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0]      IDX_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]      FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [3:0]            val_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dpm_reg;
    logic [NUM_DIGITS-1:0] blk_reg;
    logic [NUM_DIGITS-1:0] bnk_reg;

    logic [CNT_W-1:0] tick_cnt_reg;
    logic [SEL_W-1:0] idx_reg;
    logic [FRM_W-1:0] frame_cnt_reg;
    logic             blink_phase_reg;

    logic                  tick;
    logic                  frame_end;
    logic                  wr_ok;
    logic [NUM_DIGITS-1:0] nonzero;
    logic [NUM_DIGITS-1:0] keep;
    logic [NUM_DIGITS-1:0] dark;

    assign tick      = (tick_cnt_reg == CNT_LAST);
    assign frame_end = tick && (idx_reg == IDX_LAST);
    assign wr_ok     = write && !clear && (32'(sel) < NUM_DIGITS);

    function automatic logic [6:0] hex_enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // keep[i] is set when some digit at or left of i still has something to show,
    // so leading-zero suppression applies only where keep is clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nonzero[gi] = (val_reg[gi] != 4'h0) || dpm_reg[gi];
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign keep[gi] = nonzero[gi];
            end else begin : g_chain
                assign keep[gi] = nonzero[gi] | keep[gi+1];
            end
            if (gi == 0) begin : g_right
                assign dark[gi] = bnk_reg[gi] | (blk_reg[gi] & blink_phase_reg);
            end else begin : g_other
                assign dark[gi] = bnk_reg[gi] | (blk_reg[gi] & blink_phase_reg)
                                | (lz_en & ~keep[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) val_reg[i] <= 4'h0;
            dpm_reg <= '0;
            blk_reg <= '0;
            bnk_reg <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) val_reg[i] <= 4'h0;
            dpm_reg <= '0;
            blk_reg <= '0;
            bnk_reg <= '0;
        end else if (wr_ok) begin
            val_reg[sel] <= num;
            dpm_reg[sel] <= dp_in;
            blk_reg[sel] <= blink_in;
            bnk_reg[sel] <= blank_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg    <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            seg             <= 7'h7F;
            dp              <= 1'b1;
            anode           <= '1;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            if (tick) idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            if (frame_end) begin
                if (frame_cnt_reg == FRM_LAST) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
            // Outputs reflect the pre-edge scan index, hence the one-cycle lag.
            seg   <= dark[idx_reg] ? 7'h7F : hex_enc(val_reg[idx_reg]);
            dp    <= dark[idx_reg] | ~dpm_reg[idx_reg];
            anode <= ~(ONE_HOT0 << idx_reg);
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an 8-digit and a 5-digit instance, both with a 4-cycle slot
// and 2-frame blink, compared against expectations queued before each clock edge.
module tb_seg_scan_ctrl;
    localparam int N  = 8;
    localparam int N5 = 5;
    localparam int RD = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       write, clear, lz_en, dp_in, blank_in, blink_in;
    logic [2:0] sel;
    logic [3:0] num;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] anode;
    logic       write5, clear5;
    logic [2:0] sel5;
    logic [3:0] num5;
    logic [6:0] seg5;
    logic       dp5;
    logic [4:0] anode5;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .write(write), .sel(sel), .num(num),
        .dp_in(dp_in), .blank_in(blank_in), .blink_in(blink_in),
        .clear(clear), .lz_en(lz_en), .seg(seg), .dp(dp), .anode(anode)
    );

    seg_scan_ctrl #(.NUM_DIGITS(N5), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut5 (
        .clk(clk), .reset(reset), .write(write5), .sel(sel5), .num(num5),
        .dp_in(1'b0), .blank_in(1'b0), .blink_in(1'b0),
        .clear(clear5), .lz_en(1'b0), .seg(seg5), .dp(dp5), .anode(anode5)
    );

    typedef struct {
        int         unit;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] anode;
        string      name;
    } exp_t;

    typedef struct {
        logic       clr;
        logic       wr;
        logic [2:0] sel;
        logic [3:0] num;
        logic       dpi;
        logic       bnk;
        logic       lz;
        int         dig;
        logic [6:0] eseg;
        logic       edp;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[17];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic compare_pop();
        exp_t e;
        logic [6:0] s;
        logic d;
        logic [7:0] a;
        e = sb.pop_front();
        if (e.unit == 0) begin
            s = seg; d = dp; a = anode;
        end else begin
            s = seg5; d = dp5; a = {3'b000, anode5};
        end
        checks++;
        if (s !== e.seg || d !== e.dp || a !== e.anode) begin
            errors++;
            $display("FAIL %s u%0d cyc=%0d: got seg=%02h dp=%b anode=%02h, want seg=%02h dp=%b anode=%02h",
                     e.name, e.unit, cyc, s, d, a, e.seg, e.dp, e.anode);
        end else begin
            $display("ok   %s u%0d cyc=%0d: seg=%02h dp=%b anode=%02h", e.name, e.unit, cyc, s, d, a);
        end
    endtask

    task automatic push(input int unit, input logic [6:0] s, input logic d,
                        input logic [7:0] a, input string nm);
        exp_t e;
        e.unit = unit; e.seg = s; e.dp = d; e.anode = a; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0) compare_pop();
    endtask

    task automatic expect_next(input int unit, input logic [6:0] s, input logic d,
                               input logic [7:0] a, input string nm);
        push(unit, s, d, a, nm);
        step();
    endtask

    function automatic logic [7:0] anode_of(input int n, input int d);
        logic [7:0] a;
        a = (n == N) ? 8'hFF : 8'h1F;
        a[d] = 1'b0;
        return a;
    endfunction

    // Digit whose slot the outputs will show after the next edge (cyc counts edges since release).
    function automatic int idx_at_next(input int n);
        return (cyc / RD) % n;
    endfunction

    task automatic goto_digit(input int unit, input int d);
        int n;
        n = (unit == 0) ? N : N5;
        for (int i = 0; i < 2 * N * RD && idx_at_next(n) != d; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        write = 0; clear = 0; lz_en = 0; dp_in = 0; blank_in = 0; blink_in = 0;
        sel = 0; num = 0; write5 = 0; clear5 = 0; sel5 = 0; num5 = 0;

        tbl[0]  = '{0, 1, 3'd3, 4'hA, 1, 0, 0, 3, 7'h08, 0, "d3_A_dp"};
        tbl[1]  = '{0, 1, 3'd0, 4'h7, 0, 0, 0, 0, 7'h78, 1, "d0_7"};
        tbl[2]  = '{0, 0, 3'd0, 4'h0, 0, 0, 0, 3, 7'h08, 0, "d3_held"};
        tbl[3]  = '{1, 0, 3'd0, 4'h0, 0, 0, 1, 0, 7'h40, 1, "clr_d0_never_dark"};
        tbl[4]  = '{0, 0, 3'd0, 4'h0, 0, 0, 1, 1, 7'h7F, 1, "lz_d1_dark"};
        tbl[5]  = '{0, 1, 3'd2, 4'h5, 0, 0, 1, 2, 7'h12, 1, "lz_d2_5"};
        tbl[6]  = '{0, 1, 3'd0, 4'h7, 0, 0, 1, 0, 7'h78, 1, "lz_d0_7"};
        tbl[7]  = '{0, 0, 3'd0, 4'h0, 0, 0, 1, 1, 7'h40, 1, "lz_d1_inner_zero"};
        tbl[8]  = '{0, 0, 3'd0, 4'h0, 0, 0, 1, 7, 7'h7F, 1, "lz_d7_dark"};
        tbl[9]  = '{0, 0, 3'd0, 4'h0, 0, 0, 1, 3, 7'h7F, 1, "lz_d3_dark"};
        tbl[10] = '{0, 0, 3'd0, 4'h0, 0, 0, 0, 7, 7'h40, 1, "nolz_d7"};
        tbl[11] = '{0, 0, 3'd0, 4'h0, 0, 0, 0, 3, 7'h40, 1, "nolz_d3"};
        tbl[12] = '{0, 1, 3'd5, 4'h0, 1, 0, 1, 5, 7'h40, 0, "lz_d5_dp_only"};
        tbl[13] = '{0, 0, 3'd0, 4'h0, 0, 0, 1, 4, 7'h40, 1, "lz_d4_below_dp"};
        tbl[14] = '{0, 0, 3'd0, 4'h0, 0, 0, 1, 6, 7'h7F, 1, "lz_d6_dark"};
        tbl[15] = '{0, 1, 3'd1, 4'h3, 0, 1, 0, 1, 7'h7F, 1, "blank_d1"};
        tbl[16] = '{0, 1, 3'd7, 4'hF, 0, 0, 0, 7, 7'h0E, 1, "d7_F"};

        repeat (3) @(posedge clk);
        #1;
        push(0, 7'h7F, 1'b1, 8'hFF, "reset_vals");
        push(1, 7'h7F, 1'b1, 8'h1F, "reset_vals");
        compare_pop();
        compare_pop();

        @(negedge clk);
        reset = 1'b0;
        cyc = 0;

        // Anode walk on both instances.
        for (int k = 1; k <= 36; k++) begin
            push(0, 7'h40, 1'b1, anode_of(N, ((k - 1) / RD) % N), "walk");
            push(1, 7'h40, 1'b1, anode_of(N5, ((k - 1) / RD) % N5), "walk");
            step();
        end

        foreach (tbl[i]) begin
            lz_en = tbl[i].lz;
            if (tbl[i].clr || tbl[i].wr) begin
                clear = tbl[i].clr; write = tbl[i].wr; sel = tbl[i].sel; num = tbl[i].num;
                dp_in = tbl[i].dpi; blank_in = tbl[i].bnk; blink_in = 1'b0;
                step();
                clear = 0; write = 0; dp_in = 0; blank_in = 0;
            end
            goto_digit(0, tbl[i].dig);
            expect_next(0, tbl[i].eseg, tbl[i].edp, anode_of(N, tbl[i].dig), tbl[i].name);
        end

        // Blink: digit 1 dark whenever the blink phase (every BF frames) is 1.
        lz_en = 0;
        clear = 1; step(); clear = 0;
        write = 1; sel = 3'd1; num = 4'h9; blink_in = 1; step();
        write = 0; blink_in = 0;
        for (int r = 0; r < 8; r++) begin
            int ph;
            goto_digit(0, 1);
            ph = (cyc / (N * RD * BF)) % 2;
            expect_next(0, ph ? 7'h7F : 7'h10, 1'b1, anode_of(N, 1), ph ? "blink_dark" : "blink_lit");
            goto_digit(0, 2);
            expect_next(0, 7'h40, 1'b1, anode_of(N, 2), "blink_neighbour");
        end

        // Asynchronous reset in the middle of a slot.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        push(0, 7'h7F, 1'b1, 8'hFF, "async_reset");
        push(1, 7'h7F, 1'b1, 8'h1F, "async_reset");
        compare_pop();
        compare_pop();
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 5; k++)
            expect_next(0, 7'h40, 1'b1, anode_of(N, (k - 1) / RD), "restart_slot");

        // Out-of-range select on the 5-digit instance, then clear beating write.
        write5 = 1; sel5 = 3'd5; num5 = 4'h8; step(); write5 = 0;
        for (int d = 0; d < N5; d++) begin
            goto_digit(1, d);
            expect_next(1, 7'h40, 1'b1, anode_of(N5, d), "sel_oob_ignored");
        end
        write5 = 1; sel5 = 3'd4; num5 = 4'h3; step(); write5 = 0;
        goto_digit(1, 4);
        expect_next(1, 7'h30, 1'b1, anode_of(N5, 4), "d4_written");
        clear5 = 1; write5 = 1; sel5 = 3'd4; num5 = 4'h6; step();
        clear5 = 0; write5 = 0;
        goto_digit(1, 4);
        expect_next(1, 7'h40, 1'b1, anode_of(N5, 4), "clear_wins");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
